alu_seq: RTL and testbench

Parametrised, handshaked successor to the team's combinational 4-bit ALU. Operand width is configurable and the opcode set is extended with shifts, unsigned compare and an iterative shift-add multiply. Inputs and outputs use valid/ready handshakes and results are registered, so the block can sit between pipeline stages or behind an input register bank. Each accepted operation produces exactly one result.

---
 rtl/alu_seq.sv | 115 +++++++++++
 tb/tb_alu_seq.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: handshaked parametrised ALU with registered results and iterative shift-add multiply
module alu_seq #(
  parameter int WIDTH = 4,
  parameter int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic [3:0]       flags,
  output logic             err
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state_q, state_d;
  logic [SHW:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, res_q, hi_q, r;
  logic [2*WIDTH-1:0] p_q, p_d, p_step;
  logic [WIDTH:0] add_s, sub_s, step_s;
  logic [SHW-1:0] sh;
  logic [3:0] flg_q;
  logic err_q, c, v, e, accept, is_mul, mul_done;
  assign in_ready = state_q == IDLE || (state_q == DONE && out_ready);
  assign out_valid = state_q == DONE;
  assign accept = in_valid && in_ready;
  assign is_mul = op == 4'b1100;
  assign mul_done = state_q == BUSY && cnt_q == (SHW+1)'(1);
  assign step_s = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, a_q} : '0);
  assign p_step = {step_s, p_q[WIDTH-1:1]};
  assign result = res_q;
  assign result_hi = hi_q;
  assign flags = flg_q;
  assign err = err_q;
  // single-cycle operations evaluated on the live inputs, captured only on accept
  always_comb begin
    add_s = {1'b0, a} + {1'b0, b};
    sub_s = {1'b0, a} - {1'b0, b};
    sh = b[SHW-1:0];
    r = '0;
    c = 1'b0;
    v = 1'b0;
    e = 1'b0;
    case (op)
      4'h0: begin r = add_s[WIDTH-1:0]; c = add_s[WIDTH]; v = (a[WIDTH-1] == b[WIDTH-1]) && (add_s[WIDTH-1] != a[WIDTH-1]); end
      4'h1: begin r = sub_s[WIDTH-1:0]; c = ~sub_s[WIDTH]; v = (a[WIDTH-1] != b[WIDTH-1]) && (sub_s[WIDTH-1] != a[WIDTH-1]); end
      4'h2: r = ~a;
      4'h3: r = a & b;
      4'h4: r = a | b;
      4'h5: r = a ^ b;
      4'h6: r = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      4'h7: r = {{(WIDTH-1){1'b0}}, a == b};
      4'h8: r = {{(WIDTH-1){1'b0}}, a < b};
      4'h9: r = a << sh;
      4'ha: r = a >> sh;
      4'hb: r = WIDTH'($signed(a) >>> sh);
      4'hc: r = '0;
      default: e = 1'b1;
    endcase
  end
  // next state and multiply datapath: one shift-add step per BUSY cycle
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    p_d = p_q;
    if (accept) state_d = is_mul ? BUSY : DONE;
    else if (state_q == DONE && out_ready) state_d = IDLE;
    else if (mul_done) state_d = DONE;
    if (accept && is_mul) begin
      cnt_d = (SHW+1)'(WIDTH);
      p_d = {{WIDTH{1'b0}}, b};
    end else if (state_q == BUSY) begin
      cnt_d = cnt_q - (SHW+1)'(1);
      p_d = p_step;
    end
  end
  // control state and multiply registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      p_q <= '0;
      a_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      p_q <= p_d;
      if (accept && is_mul) a_q <= a;
    end
  end
  // result registers load only when entering DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      res_q <= '0;
      hi_q <= '0;
      flg_q <= '0;
      err_q <= 1'b0;
    end else if (accept && !is_mul) begin
      res_q <= r;
      hi_q <= '0;
      flg_q <= {r[WIDTH-1], r == '0, c, v};
      err_q <= e;
    end else if (mul_done) begin
      res_q <= p_step[WIDTH-1:0];
      hi_q <= p_step[2*WIDTH-1:WIDTH];
      flg_q <= {p_step[WIDTH-1], p_step[WIDTH-1:0] == '0, 1'b0, p_step[2*WIDTH-1:WIDTH] != '0};
      err_q <= 1'b0;
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed table, randomized model comparison and handshake corner sequences for alu_seq
module tb_alu_seq;
  localparam int W = 4, M = 1 << W, H = M / 2;
  typedef struct {
    logic [3:0] op;
    logic [W-1:0] a, b, r, rh;
    logic [3:0] fl;
    logic e;
    int lat;
  } vec_t;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 0;
  logic in_ready, out_valid, err;
  logic [3:0] op = 0, flags;
  logic [W-1:0] a = 0, b = 0, result, result_hi;
  int total = 0, bad = 0;
  vec_t vq[$];
  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .result_hi(result_hi),
    .flags(flags), .err(err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", n, act, exp);
    end
  endtask
  function automatic void model(input int o, input int x, input int y, output int r, output int rh, output int fl, output int e);
    int sx, sy, s, c, v, sh;
    sx = x >= H ? x - M : x;
    sy = y >= H ? y - M : y;
    sh = y % W;
    c = 0; v = 0; rh = 0; e = 0; r = 0;
    case (o)
      0: begin s = x + y; r = s % M; c = int'(s >= M); v = int'(sx + sy >= H || sx + sy < -H); end
      1: begin s = x - y; r = (s + M) % M; c = int'(x >= y); v = int'(sx - sy >= H || sx - sy < -H); end
      2: r = M - 1 - x;
      3: r = x & y;
      4: r = x | y;
      5: r = x ^ y;
      6: r = int'(sx < sy);
      7: r = int'(x == y);
      8: r = int'(x < y);
      9: r = (x << sh) % M;
      10: r = x >> sh;
      11: r = (sx >>> sh) & (M - 1);
      12: begin s = x * y; r = s % M; rh = s / M; v = int'(rh != 0); end
      default: e = 1;
    endcase
    fl = 8 * int'(r >= H) + 4 * int'(r == 0) + 2 * c + v;
  endfunction
  task automatic run(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y, input int hold,
                     output logic [W-1:0] r, output logic [W-1:0] rh, output logic [3:0] fl, output logic e, output int lat);
    int n;
    @(negedge clk);
    in_valid = 1; op = o; a = x; b = y; out_ready = 0;
    n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    chk("accept", 32'(n < 50), 1);
    @(negedge clk);
    in_valid = 0; op = 4'($urandom); a = W'($urandom); b = W'($urandom);
    lat = 1;
    while (!out_valid && lat < 50) begin
      chk("busy_ready", in_ready, 0);
      @(negedge clk);
      lat++;
    end
    r = result; rh = result_hi; fl = flags; e = err;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      chk("hold_valid", out_valid, 1);
      chk("hold_ready", in_ready, 0);
      chk("hold_data", {result, result_hi, flags, err}, {r, rh, fl, e});
    end
    out_ready = 1;
  endtask
  initial begin
    logic [W-1:0] r, rh;
    logic [3:0] fl;
    logic e;
    int lat, mr, mrh, mfl, me;
    vq.push_back('{4'h0, 4'd7, 4'd1, 4'h8, 4'h0, 4'b1001, 1'b0, 1});
    vq.push_back('{4'h1, 4'd3, 4'd5, 4'hE, 4'h0, 4'b1000, 1'b0, 1});
    vq.push_back('{4'h1, 4'd0, 4'd0, 4'h0, 4'h0, 4'b0110, 1'b0, 1});
    vq.push_back('{4'h6, 4'h8, 4'd1, 4'h1, 4'h0, 4'b0000, 1'b0, 1});
    vq.push_back('{4'h8, 4'h8, 4'd1, 4'h0, 4'h0, 4'b0100, 1'b0, 1});
    vq.push_back('{4'hB, 4'h8, 4'd1, 4'hC, 4'h0, 4'b1000, 1'b0, 1});
    vq.push_back('{4'hA, 4'h8, 4'd1, 4'h4, 4'h0, 4'b0000, 1'b0, 1});
    vq.push_back('{4'hC, 4'hF, 4'hF, 4'h1, 4'hE, 4'b0001, 1'b0, 5});
    vq.push_back('{4'hD, 4'h5, 4'h6, 4'h0, 4'h0, 4'b0100, 1'b1, 1});
    vq.push_back('{4'h7, 4'h5, 4'h5, 4'h1, 4'h0, 4'b0000, 1'b0, 1});
    vq.push_back('{4'h2, 4'h5, 4'h0, 4'hA, 4'h0, 4'b1000, 1'b0, 1});
    vq.push_back('{4'h3, 4'hC, 4'hA, 4'h8, 4'h0, 4'b1000, 1'b0, 1});
    vq.push_back('{4'h4, 4'hC, 4'hA, 4'hE, 4'h0, 4'b1000, 1'b0, 1});
    vq.push_back('{4'h5, 4'hC, 4'hA, 4'h6, 4'h0, 4'b0000, 1'b0, 1});
    vq.push_back('{4'h9, 4'h3, 4'h5, 4'h6, 4'h0, 4'b0000, 1'b0, 1});
    vq.push_back('{4'h0, 4'hF, 4'h1, 4'h0, 4'h0, 4'b0110, 1'b0, 1});
    vq.push_back('{4'hC, 4'h3, 4'h5, 4'hF, 4'h0, 4'b1000, 1'b0, 5});
    repeat (2) @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_result", result, 0);
    chk("rst_hi", result_hi, 0);
    chk("rst_flags", flags, 0);
    chk("rst_err", err, 0);
    rst = 0;
    foreach (vq[i]) begin
      run(vq[i].op, vq[i].a, vq[i].b, i % 3, r, rh, fl, e, lat);
      chk($sformatf("vec%0d_result", i), r, vq[i].r);
      chk($sformatf("vec%0d_hi", i), rh, vq[i].rh);
      chk($sformatf("vec%0d_flags", i), fl, vq[i].fl);
      chk($sformatf("vec%0d_err", i), e, vq[i].e);
      chk($sformatf("vec%0d_lat", i), lat, vq[i].lat);
    end
    for (int i = 0; i < 300; i++) begin
      logic [3:0] o;
      logic [W-1:0] x, y;
      o = 4'($urandom_range(0, 15));
      x = W'($urandom);
      y = W'($urandom);
      model(int'(o), int'(x), int'(y), mr, mrh, mfl, me);
      run(o, x, y, $urandom_range(0, 2), r, rh, fl, e, lat);
      chk($sformatf("rnd op=%0h a=%0h b=%0h result", o, x, y), r, mr);
      chk($sformatf("rnd op=%0h a=%0h b=%0h hi", o, x, y), rh, mrh);
      chk($sformatf("rnd op=%0h a=%0h b=%0h flags", o, x, y), fl, mfl);
      chk($sformatf("rnd op=%0h a=%0h b=%0h err", o, x, y), e, me);
      chk($sformatf("rnd op=%0h lat", o), lat, o == 4'hC ? W + 1 : 1);
    end
    @(negedge clk);
    out_ready = 1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin
        chk("b2b_valid", out_valid, 1);
        chk("b2b_result", result, i + 2);
        chk("b2b_ready", in_ready, 1);
      end
      in_valid = 1; op = 4'h0; a = W'(i + 2); b = 1;
      @(negedge clk);
    end
    out_ready = 0; a = 9; b = 2;
    #1;
    chk("bp_ready", in_ready, 0);
    chk("bp_result0", result, 7);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_valid", out_valid, 1);
      chk("bp_ready", in_ready, 0);
      chk("bp_result", result, 7);
      chk("bp_flags", flags, 0);
    end
    out_ready = 1;
    #1;
    chk("release_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 0;
    chk("release_valid", out_valid, 1);
    chk("release_result", result, 11);
    chk("release_flags", flags, 4'b1000);
    @(negedge clk);
    in_valid = 1; op = 4'hC; a = 4'hF; b = 4'hF;
    @(negedge clk);
    in_valid = 0;
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("abort_valid", out_valid, 0);
    chk("abort_ready", in_ready, 1);
    chk("abort_result", result, 0);
    chk("abort_hi", result_hi, 0);
    chk("abort_flags", flags, 0);
    chk("abort_err", err, 0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("abort_quiet", out_valid, 0);
    end
    run(4'hD, 4'h3, 4'h4, 1, r, rh, fl, e, lat);
    chk("ill_result", r, 0);
    chk("ill_hi", rh, 0);
    chk("ill_flags", fl, 4'b0100);
    chk("ill_err", e, 1);
    chk("ill_lat", lat, 1);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
